// File: rtl/adder_seq32_ctrl_if.sv
// Bundle of request, adder-side and result signals for the 32-bit sequenced adder front-end.
// The slave modport is the controller's view; master is the surrounding environment.
interface adder_seq32_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;

  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic [15:0] add_s;
  logic        add_cout;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_a,
    input  in_b,
    input  in_cin,
    output add_a,
    output add_b,
    output add_cin,
    input  add_s,
    input  add_cout,
    output out_valid,
    input  out_ready,
    output out_sum,
    output out_cout,
    output out_ovf
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_a,
    output in_b,
    output in_cin,
    input  add_a,
    input  add_b,
    input  add_cin,
    output add_s,
    output add_cout,
    input  out_valid,
    output out_ready,
    input  out_sum,
    input  out_cout,
    input  out_ovf
  );
endinterface

// File: rtl/adder_seq32_ctrl.sv
// Runs a 32-bit add as two passes (low half, then high half) through one external 16-bit adder,
// chaining the mid carry and returning a registered sum with carry-out and signed overflow.
module adder_seq32_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  adder_seq32_ctrl_if.slave  bus
);

  localparam logic [3:0] LastCnt = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] a_hi_q;
  logic [15:0] b_hi_q;
  logic        in_ready_q;
  logic [15:0] add_a_q;
  logic [15:0] add_b_q;
  logic        add_cin_q;
  logic        out_valid_q;
  logic [31:0] out_sum_q;
  logic        out_cout_q;
  logic        out_ovf_q;

  // Adder operands are registered and loaded one edge ahead of each pass, so they only ever
  // change on a phase boundary and read as zero whenever no pass is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      a_hi_q      <= '0;
      b_hi_q      <= '0;
      in_ready_q  <= 1'b1;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_hi_q     <= bus.in_a[31:16];
            b_hi_q     <= bus.in_b[31:16];
            add_a_q    <= bus.in_a[15:0];
            add_b_q    <= bus.in_b[15:0];
            add_cin_q  <= bus.in_cin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StLo;
          end
        end
        StLo: begin
          if (cnt_q == LastCnt) begin
            out_sum_q[15:0] <= bus.add_s;
            add_a_q         <= a_hi_q;
            add_b_q         <= b_hi_q;
            // The mid carry is held directly in the Cin register for the high pass.
            add_cin_q       <= bus.add_cout;
            cnt_q           <= '0;
            state_q         <= StHi;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StHi: begin
          if (cnt_q == LastCnt) begin
            out_sum_q[31:16] <= bus.add_s;
            out_cout_q       <= bus.add_cout;
            out_ovf_q        <= (a_hi_q[15] == b_hi_q[15]) && (bus.add_s[15] != a_hi_q[15]);
            add_a_q          <= '0;
            add_b_q          <= '0;
            add_cin_q        <= 1'b0;
            out_valid_q      <= 1'b1;
            cnt_q            <= '0;
            state_q          <= StDone;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_cin   = add_cin_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_adder_seq32_ctrl.sv
// Scoreboard bench: two controllers (settle 1 and 3), each driving a behavioural 16-bit adder,
// checked against plain 33-bit arithmetic.
module tb_adder_seq32_ctrl;

  localparam int S0 = 1;
  localparam int S1 = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adder_seq32_ctrl_if bus0 ();
  adder_seq32_ctrl_if bus1 ();

  adder_seq32_ctrl #(.SETTLE_CYCLES(S0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  adder_seq32_ctrl #(.SETTLE_CYCLES(S1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  // External combinational 16-bit adders.
  assign {bus0.add_cout, bus0.add_s} = 17'(bus0.add_a) + 17'(bus0.add_b) + 17'(bus0.add_cin);
  assign {bus1.add_cout, bus1.add_s} = 17'(bus1.add_a) + 17'(bus1.add_b) + 17'(bus1.add_cin);

  logic        in_valid_d  [2];
  logic [31:0] in_a_d      [2];
  logic [31:0] in_b_d      [2];
  logic        in_cin_d    [2];
  logic        out_ready_d [2];

  logic        in_ready_w  [2];
  logic [15:0] add_a_w     [2];
  logic [15:0] add_b_w     [2];
  logic        add_cin_w   [2];
  logic        out_valid_w [2];
  logic [31:0] out_sum_w   [2];
  logic        out_cout_w  [2];
  logic        out_ovf_w   [2];

  assign bus0.in_valid  = in_valid_d[0];
  assign bus0.in_a      = in_a_d[0];
  assign bus0.in_b      = in_b_d[0];
  assign bus0.in_cin    = in_cin_d[0];
  assign bus0.out_ready = out_ready_d[0];
  assign bus1.in_valid  = in_valid_d[1];
  assign bus1.in_a      = in_a_d[1];
  assign bus1.in_b      = in_b_d[1];
  assign bus1.in_cin    = in_cin_d[1];
  assign bus1.out_ready = out_ready_d[1];

  assign in_ready_w[0]  = bus0.in_ready;
  assign add_a_w[0]     = bus0.add_a;
  assign add_b_w[0]     = bus0.add_b;
  assign add_cin_w[0]   = bus0.add_cin;
  assign out_valid_w[0] = bus0.out_valid;
  assign out_sum_w[0]   = bus0.out_sum;
  assign out_cout_w[0]  = bus0.out_cout;
  assign out_ovf_w[0]   = bus0.out_ovf;
  assign in_ready_w[1]  = bus1.in_ready;
  assign add_a_w[1]     = bus1.add_a;
  assign add_b_w[1]     = bus1.add_b;
  assign add_cin_w[1]   = bus1.add_cin;
  assign out_valid_w[1] = bus1.out_valid;
  assign out_sum_w[1]   = bus1.out_sum;
  assign out_cout_w[1]  = bus1.out_cout;
  assign out_ovf_w[1]   = bus1.out_ovf;

  // Expected results, packed as {cout, ovf, sum}.
  logic [33:0] exp_q0 [$];
  logic [33:0] exp_q1 [$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string name, int idx, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h7FFF_FFFF;
      1:       v = 32'h8000_0000;
      2:       v = 32'h0000_FFFF;
      3:       v = 32'hFFFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Monitor: every cycle a result is presented it must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < 2; i++) begin
          if (out_valid_w[i]) begin
            logic [33:0] e;
            int          depth;
            depth = (i == 0) ? exp_q0.size() : exp_q1.size();
            if (depth == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_result dut%0d: got 0x%0h, expected no result", i,
                       out_sum_w[i]);
            end else begin
              e = (i == 0) ? exp_q0[0] : exp_q1[0];
              chk("result", i, {out_cout_w[i], out_ovf_w[i], out_sum_w[i]}, e);
              chk("in_ready_while_pending", i, in_ready_w[i], 0);
              if (out_ready_d[i]) begin
                if (i == 0) void'(exp_q0.pop_front());
                else        void'(exp_q1.pop_front());
              end
            end
          end
        end
      end
    end
  end

  // One full transaction: accept, step-by-step operand/latency checks, then result handoff.
  task automatic issue(int idx, logic [31:0] a, logic [31:0] b, logic cin, bit bp);
    int          s;
    int          w;
    bit          done;
    logic [32:0] full;
    logic [16:0] lo;
    logic [33:0] e;
    s    = (idx == 0) ? S0 : S1;
    full = {1'b0, a} + {1'b0, b} + 33'(cin);
    lo   = {1'b0, a[15:0]} + {1'b0, b[15:0]} + 17'(cin);
    e    = {full[32], (a[31] == b[31]) && (full[31] != a[31]), full[31:0]};

    in_a_d[idx]     = a;
    in_b_d[idx]     = b;
    in_cin_d[idx]   = cin;
    in_valid_d[idx] = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready_w[idx] && w < 50) begin
      w++;
      @(negedge clk);
    end
    chk("accept_wait", idx, w, 0);
    if (idx == 0) exp_q0.push_back(e);
    else          exp_q1.push_back(e);
    @(posedge clk);
    #1;
    // Operands change right after acceptance; the DUT must not notice.
    in_valid_d[idx] = 1'b0;
    in_a_d[idx]     = $urandom;
    in_b_d[idx]     = $urandom;
    in_cin_d[idx]   = 1'($urandom);
    for (int j = 0; j < 2 * s; j++) begin
      chk("add_a", idx, add_a_w[idx], (j < s) ? a[15:0] : a[31:16]);
      chk("add_b", idx, add_b_w[idx], (j < s) ? b[15:0] : b[31:16]);
      chk("add_cin", idx, add_cin_w[idx], (j < s) ? cin : lo[16]);
      chk("busy_no_valid", idx, out_valid_w[idx], 0);
      @(posedge clk);
      #1;
    end
    chk("latency_valid", idx, out_valid_w[idx], 1);
    chk("done_add_a_zero", idx, add_a_w[idx], 0);
    chk("done_add_cin_zero", idx, add_cin_w[idx], 0);

    if (bp) begin
      out_ready_d[idx] = 1'b0;
      in_valid_d[idx]  = 1'b1;
      for (int k = 0; k < 5; k++) begin
        chk("bp_in_ready", idx, in_ready_w[idx], 0);
        chk("bp_valid_held", idx, out_valid_w[idx], 1);
        @(posedge clk);
        #1;
      end
      out_ready_d[idx] = 1'b1;
      @(posedge clk);
      #1;
      out_ready_d[idx] = 1'b0;
      chk("bp_released", idx, out_valid_w[idx], 0);
    end else begin
      done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
        out_ready_d[idx] = ($urandom_range(0, 3) != 0) || (k > 20);
        @(negedge clk);
        done = out_valid_w[idx] && out_ready_d[idx];
        @(posedge clk);
        #1;
      end
      out_ready_d[idx] = 1'b0;
      chk("handoff_done", idx, done, 1);
      chk("idle_after_handoff", idx, out_valid_w[idx], 0);
    end
  endtask

  task automatic reset_mid_hi();
    logic [31:0] a;
    a = $urandom;
    in_a_d[1]     = a;
    in_b_d[1]     = $urandom;
    in_cin_d[1]   = 1'b0;
    in_valid_d[1] = 1'b1;
    @(negedge clk);
    chk("rst_test_accept", 1, in_ready_w[1], 1);
    @(posedge clk);
    #1;
    in_valid_d[1] = 1'b0;
    repeat (S1 + 1) @(posedge clk);
    #1;
    chk("rst_test_in_hi", 1, add_a_w[1], a[31:16]);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_add_a", 1, add_a_w[1], 0);
    chk("rst_add_b", 1, add_b_w[1], 0);
    chk("rst_add_cin", 1, add_cin_w[1], 0);
    chk("rst_out_valid", 1, out_valid_w[1], 0);
    chk("rst_in_ready", 1, in_ready_w[1], 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 1, in_ready_w[1], 1);
    chk("post_rst_out_valid", 1, out_valid_w[1], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    for (int i = 0; i < 2; i++) begin
      in_valid_d[i]  = 1'b0;
      in_a_d[i]      = '0;
      in_b_d[i]      = '0;
      in_cin_d[i]    = 1'b0;
      out_ready_d[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_in_ready", i, in_ready_w[i], 1);
      chk("reset_out_valid", i, out_valid_w[i], 0);
      chk("reset_out", i, {out_cout_w[i], out_ovf_w[i], out_sum_w[i]}, 0);
      chk("reset_add", i, {add_cin_w[i], add_a_w[i], add_b_w[i]}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    issue(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    issue(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    issue(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    for (int n = 0; n < 25; n++) issue(0, rnd_op(), rnd_op(), 1'($urandom), 1'b0);

    issue(1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    reset_mid_hi();
    issue(1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
    for (int n = 0; n < 15; n++) issue(1, rnd_op(), rnd_op(), 1'($urandom), 1'b0);

    w = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && w < 20) begin
      @(posedge clk);
      w++;
    end
    chk("scoreboard_empty", 0, exp_q0.size(), 0);
    chk("scoreboard_empty", 1, exp_q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adder_seq32_ctrl.md
# adder_seq32_ctrl

Sequencing front-end for the 16-bit prefix adder datapath. Accepts 32-bit add requests over a valid/ready handshake and drives the low half, then the high half, through one external 16-bit adder instance. It chains the adder's carry-out into the second pass and returns a registered 32-bit result with carry and signed overflow. It sits directly upstream of the adder's A/B/Cin inputs and directly downstream of its S/Cout outputs.

## Interface
Parameters:
- SETTLE_CYCLES, default 1: cycles each half-operand is held on the adder before S/Cout are sampled. Legal range 1..15.

Ports:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- in_a  input  32  operand A
- in_b  input  32  operand B
- in_cin  input  1  carry-in
- add_a  output  16  to adder A0..A15
- add_b  output  16  to adder B0..B15
- add_cin  output  1  to adder Cin
- add_s  input  16  from adder S0..S15
- add_cout  input  1  from adder Cout
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  32  registered sum
- out_cout  output  1  carry out of bit 31
- out_ovf  output  1  signed overflow

## Operation
- FSM states: IDLE, LO, HI, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register in_a, in_b and in_cin; clear the settle counter; go to LO.
- LO:
  - add_a=a[15:0], add_b=b[15:0], add_cin=cin_reg.
  - The counter increments each cycle. On the cycle where counter==SETTLE_CYCLES-1:
    - sum[15:0] <= add_s
    - carry_mid <= add_cout
    - clear the counter and go to HI.
- HI:
  - add_a=a[31:16], add_b=b[31:16], add_cin=carry_mid.
  - On the cycle where counter==SETTLE_CYCLES-1:
    - sum[31:16] <= add_s
    - out_cout <= add_cout
    - out_ovf <= (a[31]==b[31]) && (add_s[15]!=a[31])
    - go to DONE.
- DONE:
  - out_valid=1. out_sum, out_cout and out_ovf are held stable.
  - On out_ready: go to IDLE.
- Outside LO/HI, add_a, add_b and add_cin are driven 0. This minimises switching on the dynamic adder stages.
- in_ready=1 only in IDLE. New requests are never accepted while a result is pending, including in the cycle where DONE sees out_ready. No bypass.
- in_a, in_b and in_cin are sampled only at acceptance. Later changes are ignored.
- Result is exactly (in_a + in_b + in_cin) mod 2^32. out_cout is bit 32 of the true sum.

## Timing
- Reset (asynchronous, rst_n low) forces:
  - state=IDLE, in_ready=1
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0
  - add_a=0, add_b=0, add_cin=0
  - internal regs and counter=0
- Reset asserted mid-operation (LO/HI/DONE) discards the request with no output. in_ready=1 in the first cycle after rst_n deasserts.
- Latency: acceptance edge E. out_valid rises at edge E + 2*SETTLE_CYCLES (SETTLE_CYCLES=1: accept at edge 0, LO during cycle 1, HI during cycle 2, out_valid from edge 2).
- Throughput: one request per 2*SETTLE_CYCLES+2 cycles when out_ready is held high.
- The adder is combinational. add_s/add_cout are sampled at the end of the last settle cycle of each half, never in the cycle the operands change.
- All outputs are registered or decoded from state only. No combinational path from in_valid or out_ready to any output.

## Test plan
- 0x0000FFFF + 0x00000001, cin=0, SETTLE=1 -> out_sum=0x00010000, out_cout=0, out_ovf=0, out_valid 2 cycles after accept. add_cin=1 during HI (mid-carry propagated).
- 0xFFFFFFFF + 0x00000000, cin=1 -> out_sum=0x00000000, out_cout=1, out_ovf=0.
- 0x7FFFFFFF + 0x00000001, cin=0 -> out_sum=0x80000000, out_ovf=1, out_cout=0. Also 0x80000000+0x80000000 -> sum 0, cout=1, ovf=1.
- Backpressure: out_ready low for 5 cycles after out_valid -> out_sum/cout/ovf unchanged and in_ready=0 throughout. A new in_valid during this time is not accepted. Accepted on the cycle after out_ready.
- SETTLE_CYCLES=3, 0x12345678+0x11111111 -> 0x23456789 after 6 cycles. add_a=0x5678 held for exactly 3 cycles, then 0x1234 for 3 cycles.
- rst_n pulsed low during HI -> out_valid stays 0, add_* go to 0 immediately (asynchronous), in_ready=1 after release. Next request completes correctly.
